// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier sequencing logic.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } step_state_t;

    localparam int BOOTH_CNT_WIDTH = 5;

endpackage

// File: rtl/step_counter.sv
// Partial-product step counter for the Booth multiplier: counts `limit` steps
// per operation in up or down mode and pulses `done` after the final step.
//
// state | meaning
// IDLE  | waiting for start; count holds terminal value (0 after reset/abort)
// RUN   | busy; each en_pp completes one step
// DONE  | one-cycle done pulse; a start here restarts with no bubble
module step_counter
    import booth_pkg::*;
#(
    parameter int WIDTH      = BOOTH_CNT_WIDTH,
    parameter bit COUNT_DOWN = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             en_pp,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done
);

    step_state_t      state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             busy_q;
    logic             done_q;
    logic             last_w;

    // Terminal compare: the next accepted step is the final one.
    always_comb begin
        last_w = 1'b0;
        if (state_q == RUN) begin
            if (COUNT_DOWN) begin
                last_w = (count_q == WIDTH'(1));
            end else begin
                last_w = (count_q == WIDTH'(limit_q - WIDTH'(1)));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        limit_d = limit;
                        count_d = COUNT_DOWN ? limit : '0;
                        state_d = (limit != '0) ? RUN : DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (en_pp) begin
                        if (COUNT_DOWN) begin
                            count_d = WIDTH'(count_q - WIDTH'(1));
                        end else begin
                            count_d = WIDTH'(count_q + WIDTH'(1));
                        end
                        if (last_w) begin
                            state_d = DONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign last  = last_w;
    assign done  = done_q;

endmodule
